// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NUM_REGS x DATA_W register file with two combinational
// read ports, one write port and a per-register busy scoreboard.
// The issue stage reserves a destination (busy=1); writeback clears it.
//
// Reserve handshake: Reserve acts as valid, ReserveOk acts as ready. A
// reservation takes effect only on a rising edge where Reserve && ReserveOk;
// otherwise it is dropped and the requester must hold Reserve/ReserveReg
// stable until ReserveOk is seen high. ReserveOk does not depend on Reserve.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ReadReg1,
  input  logic [ADDR_W-1:0]   ReadReg2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic                ReadBusy1,
  output logic                ReadBusy2,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   WriteReg,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic                Reserve,
  input  logic [ADDR_W-1:0]   ReserveReg,
  output logic                ReserveOk,
  output logic [NUM_REGS-1:0] BusyVec,
  output logic [ADDR_W:0]     BusyCount
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     count_next;

  logic wr_eff;
  logic rsv_zero;
  logic rsv_eff;
  logic cnt_inc;
  logic cnt_dec;

  // Qualify write and reserve requests; r0 is inert when hardwired.
  always_comb begin
    wr_eff    = RegWrite && !(ZR && (WriteReg == '0));
    rsv_zero  = ZR && (ReserveReg == '0);
    ReserveOk = rsv_zero || !busy[ReserveReg] || (wr_eff && (WriteReg == ReserveReg));
    rsv_eff   = Reserve && ReserveOk && !rsv_zero;
  end

  // Next scoreboard: writeback clears first, then a reserve sets (reserve wins).
  always_comb begin
    busy_next = busy;
    if (wr_eff)  busy_next[WriteReg]   = 1'b0;
    if (rsv_eff) busy_next[ReserveReg] = 1'b1;
  end

  // Incremental popcount; a write+reserve of the same busy register nets zero.
  always_comb begin
    cnt_inc    = rsv_eff && !busy[ReserveReg];
    cnt_dec    = wr_eff && busy[WriteReg] && !(rsv_eff && (ReserveReg == WriteReg));
    count_next = count;
    if (cnt_inc && !cnt_dec)      count_next = count + CNT_ONE;
    else if (cnt_dec && !cnt_inc) count_next = count - CNT_ONE;
  end

  // Register data storage; reset overrides any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Scoreboard bits and busy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_next;
      count <= count_next;
    end
  end

  // Read port 1: base value, optional write bypass, optional zero register.
  always_comb begin
    ReadData1 = regs[ReadReg1];
    ReadBusy1 = busy[ReadReg1];
    if (BP && wr_eff && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
      ReadBusy1 = 1'b0;
    end
    if (ZR && (ReadReg1 == '0)) begin
      ReadData1 = '0;
      ReadBusy1 = 1'b0;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    ReadData2 = regs[ReadReg2];
    ReadBusy2 = busy[ReadReg2];
    if (BP && wr_eff && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
      ReadBusy2 = 1'b0;
    end
    if (ZR && (ReadReg2 == '0)) begin
      ReadData2 = '0;
      ReadBusy2 = 1'b0;
    end
  end

  assign BusyVec   = busy;
  assign BusyCount = count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard. Two instances share stimulus:
// u_a uses the defaults (ZERO_REG=1, BYPASS=1), u_b uses ZERO_REG=0, BYPASS=0.
// Each cycle the driver sets inputs and queues expected values; the monitor
// pops and compares them on the falling edge.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 3;

  // kind codes packed into the upper nibble of each queue entry
  localparam logic [3:0] K_RD1_A = 4'd0, K_RD2_A = 4'd1, K_RB1_A = 4'd2,
                         K_RB2_A = 4'd3, K_BV_A  = 4'd4, K_BC_A  = 4'd5,
                         K_ROK_A = 4'd6, K_RD1_B = 4'd7, K_RB1_B = 4'd8,
                         K_BC_B  = 4'd9, K_RD2_B = 4'd10;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] rr1, rr2, wreg, rsvreg;
  logic          regwrite, reserve;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic          rb1_a, rb2_a, rb1_b, rb2_b, rok_a, rok_b;
  logic [NR-1:0] bv_a, bv_b;
  logic [AW:0]   bc_a, bc_b;

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset),
    .ReadReg1(rr1), .ReadReg2(rr2),
    .ReadData1(rd1_a), .ReadData2(rd2_a),
    .ReadBusy1(rb1_a), .ReadBusy2(rb2_a),
    .RegWrite(regwrite), .WriteReg(wreg), .WriteData(wdata),
    .Reserve(reserve), .ReserveReg(rsvreg), .ReserveOk(rok_a),
    .BusyVec(bv_a), .BusyCount(bc_a)
  );

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset),
    .ReadReg1(rr1), .ReadReg2(rr2),
    .ReadData1(rd1_b), .ReadData2(rd2_b),
    .ReadBusy1(rb1_b), .ReadBusy2(rb2_b),
    .RegWrite(regwrite), .WriteReg(wreg), .WriteData(wdata),
    .Reserve(reserve), .ReserveReg(rsvreg), .ReserveOk(rok_b),
    .BusyVec(bv_b), .BusyCount(bc_b)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  logic [31:0] mon_act;

  function automatic string kind_name(input logic [3:0] k);
    case (k)
      K_RD1_A: return "a.ReadData1";
      K_RD2_A: return "a.ReadData2";
      K_RB1_A: return "a.ReadBusy1";
      K_RB2_A: return "a.ReadBusy2";
      K_BV_A:  return "a.BusyVec";
      K_BC_A:  return "a.BusyCount";
      K_ROK_A: return "a.ReserveOk";
      K_RD1_B: return "b.ReadData1";
      K_RB1_B: return "b.ReadBusy1";
      K_BC_B:  return "b.BusyCount";
      K_RD2_B: return "b.ReadData2";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [3:0] k);
    case (k)
      K_RD1_A: return rd1_a;
      K_RD2_A: return rd2_a;
      K_RB1_A: return {31'd0, rb1_a};
      K_RB2_A: return {31'd0, rb2_a};
      K_BV_A:  return {24'd0, bv_a};
      K_BC_A:  return {28'd0, bc_a};
      K_ROK_A: return {31'd0, rok_a};
      K_RD1_B: return rd1_b;
      K_RB1_B: return {31'd0, rb1_b};
      K_BC_B:  return {28'd0, bc_b};
      K_RD2_B: return rd2_b;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // monitor: compare every expectation queued for this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e[35:32]);
      checks++;
      if (mon_act !== mon_e[31:0]) begin
        errors++;
        $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                 kind_name(mon_e[35:32]), $time, mon_act, mon_e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic exp_val(input logic [3:0] k, input logic [31:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic idle();
    regwrite = 1'b0;
    reserve  = 1'b0;
    wreg     = '0;
    wdata    = '0;
    rsvreg   = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    regwrite = 1'b1;
    wreg     = a;
    wdata    = d;
  endtask

  task automatic do_reserve(input logic [AW-1:0] a);
    reserve = 1'b1;
    rsvreg  = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rr1 = '0;
    rr2 = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // reset state on every address
    for (int a = 0; a < NR; a++) begin
      idle();
      rr1 = AW'(a);
      rr2 = AW'(NR - 1 - a);
      rsvreg = AW'(a);
      exp_val(K_RD1_A, 32'h0);
      exp_val(K_RD2_A, 32'h0);
      exp_val(K_RB1_A, 32'h0);
      exp_val(K_RB2_A, 32'h0);
      exp_val(K_BV_A, 32'h0);
      exp_val(K_BC_A, 32'h0);
      exp_val(K_ROK_A, 32'h1);
      exp_val(K_RD1_B, 32'h0);
      tick();
    end

    // write r3 with same-cycle read: bypass vs registered visibility
    idle(); do_write(3, 32'hDEADBEEF); rr1 = 3;
    exp_val(K_RD1_A, 32'hDEADBEEF);
    exp_val(K_RD1_B, 32'h0);
    tick();
    idle(); rr1 = 3;
    exp_val(K_RD1_A, 32'hDEADBEEF);
    exp_val(K_RD1_B, 32'hDEADBEEF);
    tick();

    // reserve r5, then a dropped second request, then writeback
    idle(); do_reserve(5); rr1 = 5;
    exp_val(K_RB1_A, 32'h0);
    exp_val(K_ROK_A, 32'h1);
    exp_val(K_BC_A, 32'h0);
    tick();
    idle(); do_reserve(5); rr1 = 5; rr2 = 5;
    exp_val(K_RB1_A, 32'h1);
    exp_val(K_RB2_A, 32'h1);
    exp_val(K_BV_A, 32'h20);
    exp_val(K_BC_A, 32'h1);
    exp_val(K_ROK_A, 32'h0);
    exp_val(K_RB1_B, 32'h1);
    tick();
    idle(); rr1 = 5;
    exp_val(K_BC_A, 32'h1);
    exp_val(K_BC_B, 32'h1);
    tick();
    idle(); do_write(5, 32'h1234); rsvreg = 5; rr1 = 5;
    exp_val(K_RD1_A, 32'h1234);
    exp_val(K_RB1_A, 32'h0);
    exp_val(K_ROK_A, 32'h1);
    exp_val(K_RD1_B, 32'h0);
    exp_val(K_RB1_B, 32'h1);
    tick();
    idle(); rr1 = 5;
    exp_val(K_BC_A, 32'h0);
    exp_val(K_BV_A, 32'h0);
    exp_val(K_RD1_A, 32'h1234);
    exp_val(K_RD1_B, 32'h1234);
    exp_val(K_BC_B, 32'h0);
    tick();

    // write and reserve busy r2 in the same cycle
    idle(); do_reserve(2);
    tick();
    idle(); do_write(2, 32'hA5A50002); do_reserve(2); rr1 = 2;
    exp_val(K_ROK_A, 32'h1);
    exp_val(K_RD1_A, 32'hA5A50002);
    exp_val(K_RB1_A, 32'h0);
    exp_val(K_BC_A, 32'h1);
    exp_val(K_RB1_B, 32'h1);
    exp_val(K_RD1_B, 32'h0);
    tick();
    idle(); rr1 = 2;
    exp_val(K_RD1_A, 32'hA5A50002);
    exp_val(K_RB1_A, 32'h1);
    exp_val(K_BV_A, 32'h04);
    exp_val(K_BC_A, 32'h1);
    exp_val(K_BC_B, 32'h1);
    exp_val(K_RD1_B, 32'hA5A50002);
    tick();
    idle(); do_write(2, 32'h0);
    tick();
    idle();
    exp_val(K_BC_A, 32'h0);
    exp_val(K_BC_B, 32'h0);
    tick();

    // register zero: write and reserve r0
    idle(); do_write(0, 32'hFFFF); do_reserve(0); rr1 = 0;
    exp_val(K_ROK_A, 32'h1);
    exp_val(K_RD1_A, 32'h0);
    exp_val(K_RB1_A, 32'h0);
    exp_val(K_RD1_B, 32'h0);
    tick();
    idle(); rr1 = 0;
    exp_val(K_RD1_A, 32'h0);
    exp_val(K_RB1_A, 32'h0);
    exp_val(K_BC_A, 32'h0);
    exp_val(K_BV_A, 32'h0);
    exp_val(K_RD1_B, 32'hFFFF);
    exp_val(K_RB1_B, 32'h1);
    exp_val(K_BC_B, 32'h1);
    tick();
    idle(); do_write(0, 32'h0);
    tick();
    idle();
    exp_val(K_BC_B, 32'h0);
    tick();

    // reset wins over a same-cycle write to r1
    idle(); reset = 1'b1; do_write(1, 32'h77);
    tick();
    reset = 1'b0;
    idle(); rr1 = 1;
    exp_val(K_RD1_A, 32'h0);
    exp_val(K_RD1_B, 32'h0);
    exp_val(K_RD2_A, 32'h0);
    tick();

    // reserve every nonzero register, one per cycle
    for (int i = 1; i < NR; i++) begin
      idle(); do_reserve(AW'(i));
      exp_val(K_BC_A, 32'(i - 1));
      exp_val(K_BV_A, 32'((1 << i) - 2));
      exp_val(K_ROK_A, 32'h1);
      exp_val(K_BC_B, 32'(i - 1));
      tick();
    end
    idle(); rsvreg = 3;
    exp_val(K_BC_A, 32'(NR - 1));
    exp_val(K_BV_A, 32'hFE);
    exp_val(K_ROK_A, 32'h0);
    exp_val(K_BC_B, 32'(NR - 1));
    tick();

    // write them all back; count must step down to zero without wrapping
    for (int i = 1; i < NR; i++) begin
      idle(); do_write(AW'(i), 32'(i) * 32'h11111111);
      exp_val(K_BC_A, 32'(NR - i));
      tick();
    end
    idle(); rr1 = 7; rr2 = 6;
    exp_val(K_BC_A, 32'h0);
    exp_val(K_BV_A, 32'h0);
    exp_val(K_BC_B, 32'h0);
    exp_val(K_RD1_A, 32'h77777777);
    exp_val(K_RD2_A, 32'h66666666);
    exp_val(K_RD1_B, 32'h77777777);
    exp_val(K_RD2_B, 32'h66666666);
    tick();
    idle();
    exp_val(K_BC_A, 32'h0);
    tick();

    // final report
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
